// File: rtl/prog_lut_pkg.sv
// Shared defaults for the programmable lookup-table pipeline.
// Holds the default geometry, the reset table and its unpacking helper.
package prog_lut_pkg;

    localparam int IN_W_DEF  = 3;
    localparam int OUT_W_DEF = 2;
    localparam int CNT_W_DEF = 16;

    localparam int DEPTH_DEF = 1 << IN_W_DEF;
    localparam int TBL_W_DEF = OUT_W_DEF * DEPTH_DEF;

    // 0..7 -> 01,11,00,10,01,10,11,01
    localparam logic [TBL_W_DEF-1:0] DEF_TABLE_DEF =
        16'h798D;

    function automatic logic [OUT_W_DEF-1:0] def_entry(
        input logic [IN_W_DEF-1:0] i
    );
        return DEF_TABLE_DEF[i*OUT_W_DEF +: OUT_W_DEF];
    endfunction

endpackage

// File: rtl/prog_lut_store.sv
// Flop-array table store for prog_lut_pipe.
// Resets/restores to the packed default table; one write, one read port.
module prog_lut_store
    import prog_lut_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter logic [(OUT_W<<IN_W)-1:0] DEF_TABLE = DEF_TABLE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IN_W-1:0]  waddr,
    input  logic [OUT_W-1:0] wdata,
    input  logic             restore,
    input  logic [IN_W-1:0]  raddr,
    output logic [OUT_W-1:0] rdata
);

    localparam int DEPTH = 1 << IN_W;

    logic [OUT_W-1:0] mem [DEPTH];

    // Table contents: default on reset or restore, restore beats write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DEF_TABLE[i*OUT_W +: OUT_W];
            end
        end else if (restore) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DEF_TABLE[i*OUT_W +: OUT_W];
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-edge contents, giving read-before-write.
    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_lut_pipe.sv
// Pipelined programmable code map with valid/ready stream.
// One registered output stage, config write port and lookup counter.
module prog_lut_pipe
    import prog_lut_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter logic [(OUT_W<<IN_W)-1:0] DEF_TABLE = DEF_TABLE_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_code,
    input  logic             cfg_we,
    input  logic [IN_W-1:0]  cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             cfg_restore,
    output logic [CNT_W-1:0] lookup_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             acc;
    logic [OUT_W-1:0] rd_data;

    prog_lut_store #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .DEF_TABLE (DEF_TABLE)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .we      (cfg_we),
        .waddr   (cfg_addr),
        .wdata   (cfg_data),
        .restore (cfg_restore),
        .raddr   (in_code),
        .rdata   (rd_data)
    );

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;

    // Output stage: load on accept, drop valid once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_code  <= '0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_code  <= rd_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of accepted lookups.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_cnt <= '0;
        end else if (acc && lookup_cnt != CNT_MAX) begin
            lookup_cnt <= lookup_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_prog_lut_pipe.sv
// Randomised self-checking bench for prog_lut_pipe.
// Reference model tracks table, output slot and counters abstractly.
module tb_prog_lut_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = '0;
    logic       out_ready = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [1:0] cfg_data = '0;
    logic       cfg_restore = 1'b0;

    logic        in_ready, out_valid;
    logic [1:0]  out_code;
    logic [15:0] lookup_cnt;
    logic        in_ready4, out_valid4;
    logic [1:0]  out_code4;
    logic [3:0]  lookup_cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    int def_t [8] = '{1, 3, 0, 2, 1, 2, 3, 1};
    int tbl   [8];
    int m_valid;
    int m_code;
    int m_cnt;

    always #5 clk = ~clk;

    prog_lut_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_restore (cfg_restore),
        .lookup_cnt  (lookup_cnt)
    );

    prog_lut_pipe #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready4),
        .in_code     (in_code),
        .out_valid   (out_valid4),
        .out_ready   (out_ready),
        .out_code    (out_code4),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_restore (cfg_restore),
        .lookup_cnt  (lookup_cnt4)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        tbl     = def_t;
        m_valid = 0;
        m_code  = 0;
        m_cnt   = 0;
    endtask

    task automatic drive(
        input logic       v,
        input logic [2:0] c,
        input logic       r,
        input logic       we,
        input logic [2:0] a,
        input logic [1:0] d,
        input logic       rs
    );
        in_valid    = v;
        in_code     = c;
        out_ready   = r;
        cfg_we      = we;
        cfg_addr    = a;
        cfg_data    = d;
        cfg_restore = rs;
    endtask

    task automatic check_outs(input string tag);
        int c4;
        c4 = (m_cnt > 15) ? 15 : m_cnt;
        chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "_code"}, 32'(out_code), 32'(m_code));
        chk({tag, "_cnt"}, 32'(lookup_cnt), 32'(m_cnt));
        chk({tag, "_cnt4"}, 32'(lookup_cnt4), 32'(c4));
        chk({tag, "_code4"}, 32'(out_code4), 32'(m_code));
    endtask

    task automatic step(input string tag);
        bit rdy;
        bit acc;
        #1;
        rdy = (m_valid == 0) || out_ready;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, "_in_ready4"}, 32'(in_ready4), 32'(rdy));
        acc = in_valid && rdy;
        @(posedge clk);
        if (acc) begin
            m_code  = tbl[in_code];
            m_valid = 1;
            if (m_cnt < 65535) m_cnt++;
        end else if (out_ready) begin
            m_valid = 0;
        end
        if (cfg_restore) tbl = def_t;
        else if (cfg_we) tbl[cfg_addr] = int'(cfg_data);
        #1;
        check_outs(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("rst");
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Stream all codes with downstream always ready
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'(i), 1, 0, 0, 0, 0);
            step("t1");
            chk("t1_map", 32'(out_code), 32'(def_t[i]));
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        step("t1_drain");
        chk("t1_cnt8", 32'(lookup_cnt), 32'd8);

        // Backpressure: result held, no extra accepts
        drive(1, 3'd1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("t2_hold");
        chk("t2_code", 32'(out_code), 32'd3);
        chk("t2_cnt", 32'(lookup_cnt), 32'd9);
        drive(1, 3'd3, 1, 0, 0, 0, 0);
        step("t2_rel");
        chk("t2_rel_code", 32'(out_code), 32'd2);

        // Write and lookup same address in one cycle
        drive(1, 3'd2, 1, 1, 3'd2, 2'd3, 0);
        step("t3_rbw");
        chk("t3_old", 32'(out_code), 32'd0);
        drive(1, 3'd2, 1, 0, 0, 0, 0);
        step("t3_new");
        chk("t3_newv", 32'(out_code), 32'd3);

        // Restore beats simultaneous write
        drive(0, 0, 1, 1, 3'd5, 2'd0, 1);
        step("t4_rw");
        drive(1, 3'd5, 1, 0, 0, 0, 0);
        step("t4_lk");
        chk("t4_val", 32'(out_code), 32'd2);

        // Random traffic with occasional config activity
        for (int i = 0; i < 400; i++) begin
            drive(
                1'($urandom_range(0, 3) != 0),
                3'($urandom),
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 5) == 0),
                3'($urandom),
                2'($urandom),
                1'($urandom_range(0, 40) == 0)
            );
            step("rnd");
        end
        chk("sat4", 32'(lookup_cnt4), 32'd15);

        // Overwrite code 2, park a result, then reset mid-cycle
        drive(0, 0, 1, 1, 3'd2, 2'd3, 0);
        step("t6_wr");
        drive(1, 3'd2, 0, 0, 0, 0, 0);
        step("t6_park");
        chk("t6_parked", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outs("t6_async");
        #1;
        rst = 1'b0;
        drive(1, 3'd2, 1, 0, 0, 0, 0);
        step("t6_lk");
        chk("t6_def2", 32'(out_code), 32'd0);
        drive(0, 0, 1, 0, 0, 0, 0);
        step("t6_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
